alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch_pkg.sv | 86 ++++++++
 rtl/alu_dispatch_instr_fifo.sv | 59 +++++
 rtl/alu_dispatch.sv | 164 ++++++++++++++++
 tb/tb_alu_dispatch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU dispatch block: MIPS opcode/funct codes,
// FSM state encoding, instruction class decode and the default queue depth.
package alu_dispatch_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMMIT} state_e;

  // How the commit stage treats an instruction
  typedef enum logic [2:0] {
    K_ALU,      // write alu_result
    K_ALU_OVF,  // write alu_result unless the ALU flags overflow
    K_SLT,      // write the less flag
    K_BEQ,
    K_BNE,
    K_LW,
    K_SW,
    K_ILL
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [4:0] dest;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d.kind = K_ILL;
    d.dest = instr[20:16];
    if (instr[31:26] == OP_RTYPE) begin
      d.dest = instr[15:11];
      case (instr[5:0])
        FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
        FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR: d.kind = K_ALU;
        FN_ADD, FN_SUB:                                  d.kind = K_ALU_OVF;
        FN_SLT, FN_SLTU:                                 d.kind = K_SLT;
        default:                                         d.kind = K_ILL;
      endcase
    end else begin
      case (instr[31:26])
        OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: d.kind = K_ALU;
        OP_ADDI:                            d.kind = K_ALU_OVF;
        OP_SLTI, OP_SLTIU:                  d.kind = K_SLT;
        OP_BEQ:                             d.kind = K_BEQ;
        OP_BNE:                             d.kind = K_BNE;
        OP_LW:                              d.kind = K_LW;
        OP_SW:                              d.kind = K_SW;
        default:                            d.kind = K_ILL;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_dispatch_instr_fifo.sv
// Instruction queue: power-of-two depth, 32-bit entries, pointers wrap
// naturally. Push while full and pop while empty are ignored.
module instr_fifo
  import alu_dispatch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty/count gate every read,
    // so stale entries are never observed and the array can map to RAM.
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_dispatch.sv
// Issues queued MIPS instructions to an external combinational ALU, one at a
// time, and commits the result: GPR writeback, branch resolve, memory request
// or error pulse. IDLE -> EXEC -> COMMIT, back-to-back issue from COMMIT.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_rega,
  output logic [31:0] alu_regb,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        ovf_err,
  output logic        ill_err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state;
  logic [31:0]   gpr [32];
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] fifo_count;
  decode_t       dec;
  logic          wr_en;
  logic [31:0]   wr_data;

  assign in_ready  = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push = in_valid && !fifo_full;
  // A new instruction issues from IDLE or COMMIT, never while one is in EXEC
  assign fifo_pop  = (state != S_EXEC) && !fifo_empty;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign dbg_data  = (dbg_addr == 5'd0) ? 32'd0 : gpr[dbg_addr];

  instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_instr),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Decide the writeback for the instruction currently in EXEC
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    dec     = decode(alu_instr);
    wr_en   = 1'b0;
    wr_data = alu_result;
    if (state == S_EXEC) begin
      case (dec.kind)
        K_ALU:     wr_en = 1'b1;
        K_ALU_OVF: wr_en = !alu_flags[0];
        K_SLT: begin
          wr_en   = 1'b1;
          wr_data = {31'b0, alu_flags[1]};
        end
        default:   wr_en = 1'b0;
      endcase
    end
  end

  // GPR file: written at the end of EXEC so the following issue sees it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (wr_en && (dec.dest != 5'd0)) begin
      gpr[dec.dest] <= wr_data;
    end
  end

  // Issue/commit sequencer with registered operand and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      alu_instr    <= '0;
      alu_rega     <= '0;
      alu_regb     <= '0;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ovf_err      <= 1'b0;
      ill_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      ovf_err      <= 1'b0;
      ill_err      <= 1'b0;
      case (state)
        S_IDLE, S_COMMIT: begin
          if (!fifo_empty) begin
            alu_instr <= fifo_rdata;
            alu_rega  <= gpr[fifo_rdata[25:21]];
            alu_regb  <= gpr[fifo_rdata[20:16]];
            state     <= S_EXEC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          state    <= S_COMMIT;
          wb_valid <= wr_en;
          wb_addr  <= dec.dest;
          wb_data  <= wr_data;
          case (dec.kind)
            K_ALU_OVF: ovf_err <= alu_flags[0];
            K_BEQ: begin
              branch_valid <= 1'b1;
              branch_taken <= alu_flags[2];
            end
            K_BNE: begin
              branch_valid <= 1'b1;
              branch_taken <= !alu_flags[2];
            end
            K_LW, K_SW: begin
              mem_valid <= 1'b1;
              mem_we    <= (dec.kind == K_SW);
              mem_addr  <= alu_result;
              mem_wdata <= alu_regb;
            end
            K_ILL:     ill_err <= 1'b1;
            default:   ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch. Supplies a behavioural combinational ALU
// on the alu_* interface and checks commit pulses against hand-computed values.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] alu_instr, alu_rega, alu_regb;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        branch_valid, branch_taken;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        ovf_err, ill_err;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_dispatch #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .alu_instr    (alu_instr),
    .alu_rega     (alu_rega),
    .alu_regb     (alu_regb),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .mem_valid    (mem_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .ovf_err      (ovf_err),
    .ill_err      (ill_err),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .busy         (busy)
  );

  // External ALU: flags = {zero, less, overflow}
  always_comb begin
    logic [31:0] a, b, imm_s, imm_z;
    logic [4:0]  sh;
    logic        less, ovf;
    a      = alu_rega;
    b      = alu_regb;
    sh     = alu_instr[10:6];
    imm_s  = {{16{alu_instr[15]}}, alu_instr[15:0]};
    imm_z  = {16'h0, alu_instr[15:0]};
    alu_result = '0;
    less   = 1'b0;
    ovf    = 1'b0;
    if (alu_instr[31:26] == 6'h00) begin
      case (alu_instr[5:0])
        6'h00: alu_result = b << sh;
        6'h02: alu_result = b >> sh;
        6'h03: alu_result = $signed(b) >>> sh;
        6'h04: alu_result = b << a[4:0];
        6'h06: alu_result = b >> a[4:0];
        6'h07: alu_result = $signed(b) >>> a[4:0];
        6'h20: begin
          alu_result = a + b;
          ovf = (a[31] == b[31]) && (alu_result[31] != a[31]);
        end
        6'h21: alu_result = a + b;
        6'h22: begin
          alu_result = a - b;
          ovf = (a[31] != b[31]) && (alu_result[31] != a[31]);
        end
        6'h23: alu_result = a - b;
        6'h24: alu_result = a & b;
        6'h25: alu_result = a | b;
        6'h26: alu_result = a ^ b;
        6'h27: alu_result = ~(a | b);
        6'h2A: less = $signed(a) < $signed(b);
        6'h2B: less = a < b;
        default: alu_result = '0;
      endcase
    end else begin
      case (alu_instr[31:26])
        6'h08: begin
          alu_result = a + imm_s;
          ovf = (a[31] == imm_s[31]) && (alu_result[31] != a[31]);
        end
        6'h09: alu_result = a + imm_s;
        6'h0A: less = $signed(a) < $signed(imm_s);
        6'h0B: less = a < imm_s;
        6'h0C: alu_result = a & imm_z;
        6'h0D: alu_result = a | imm_z;
        6'h0E: alu_result = a ^ imm_z;
        6'h04, 6'h05: alu_result = a - b;
        6'h23, 6'h2B: alu_result = a + imm_s;
        default: alu_result = '0;
      endcase
    end
    alu_flags = {(alu_result == 32'd0), less, ovf};
  end

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_gpr(input string tag, input logic [4:0] addr,
                           input logic [31:0] expected);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, expected);
  endtask

  // Push one instruction into an idle block and return at the negedge of its
  // COMMIT cycle (accept edge + 3 cycles).
  task automatic exec(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] rdy_exp;
    int         pushed;
    logic       wb_exp;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset_alu_instr", alu_instr, 32'd0);
    check_gpr("reset_gpr1", 5'd1, 32'd0);

    // addi $1,$0,5: writeback exactly at accept + 3
    in_valid = 1'b1;
    in_instr = 32'h2001_0005;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_wb", {31'b0, wb_valid}, 32'd0);
    check("lat_t1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("lat_t2_wb", {31'b0, wb_valid}, 32'd0);
    check("lat_t2_alu_instr", alu_instr, 32'h2001_0005);
    @(negedge clk);
    check("lat_t3_wb", {31'b0, wb_valid}, 32'd1);
    check("addi_wb_addr", {27'b0, wb_addr}, 32'd1);
    check("addi_wb_data", wb_data, 32'd5);
    check_gpr("addi_gpr1", 5'd1, 32'd5);
    @(negedge clk);
    check("lat_t4_wb", {31'b0, wb_valid}, 32'd0);

    // Build $1 = 0x7FFFFFFF, $2 = 1
    exec(i_type(6'h08, 5'd0, 5'd1, 16'hFFFF));
    check("addi_neg_data", wb_data, 32'hFFFF_FFFF);
    exec(r_type(5'd0, 5'd1, 5'd1, 5'd1, 6'h02));
    check("srl_data", wb_data, 32'h7FFF_FFFF);
    exec(i_type(6'h08, 5'd0, 5'd2, 16'h0001));
    check("addi_2_data", wb_data, 32'd1);

    // add overflow: no writeback, ovf_err pulse
    exec(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    check("add_ovf_err", {31'b0, ovf_err}, 32'd1);
    check("add_ovf_wb", {31'b0, wb_valid}, 32'd0);
    check_gpr("add_ovf_gpr3", 5'd3, 32'd0);

    // $1 = -1; slt vs sltu
    exec(i_type(6'h08, 5'd0, 5'd1, 16'hFFFF));
    exec(r_type(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A));
    check("slt_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("slt_wb_addr", {27'b0, wb_addr}, 32'd4);
    check("slt_wb_data", wb_data, 32'd1);
    exec(r_type(5'd1, 5'd2, 5'd5, 5'd0, 6'h2B));
    check("sltu_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("sltu_wb_data", wb_data, 32'd0);
    check_gpr("slt_gpr4", 5'd4, 32'd1);

    // Branches
    exec(i_type(6'h04, 5'd1, 5'd1, 16'h0000));
    check("beq_valid", {31'b0, branch_valid}, 32'd1);
    check("beq_taken", {31'b0, branch_taken}, 32'd1);
    check("beq_wb", {31'b0, wb_valid}, 32'd0);
    exec(i_type(6'h05, 5'd1, 5'd1, 16'h0000));
    check("bne_valid", {31'b0, branch_valid}, 32'd1);
    check("bne_taken", {31'b0, branch_taken}, 32'd0);

    // Memory: sw $2,16($0) then lw $0,4($2)
    exec(i_type(6'h2B, 5'd0, 5'd2, 16'h0010));
    check("sw_valid", {31'b0, mem_valid}, 32'd1);
    check("sw_we", {31'b0, mem_we}, 32'd1);
    check("sw_addr", mem_addr, 32'h10);
    check("sw_wdata", mem_wdata, 32'd1);
    check("sw_wb", {31'b0, wb_valid}, 32'd0);
    exec(i_type(6'h23, 5'd2, 5'd0, 16'h0004));
    check("lw_valid", {31'b0, mem_valid}, 32'd1);
    check("lw_we", {31'b0, mem_we}, 32'd0);
    check("lw_addr", mem_addr, 32'd5);

    // Illegal opcode and illegal funct; execution continues afterwards
    exec(32'hFC00_0000);
    check("ill_op_err", {31'b0, ill_err}, 32'd1);
    check("ill_op_wb", {31'b0, wb_valid}, 32'd0);
    exec(r_type(5'd1, 5'd2, 5'd7, 5'd0, 6'h3F));
    check("ill_fn_err", {31'b0, ill_err}, 32'd1);
    exec(r_type(5'd1, 5'd2, 5'd8, 5'd0, 6'h21));
    check("addu_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("addu_wb_data", wb_data, 32'd0);
    check("addu_ill_clear", {31'b0, ill_err}, 32'd0);
    exec(r_type(5'd2, 5'd1, 5'd9, 5'd0, 6'h22));
    check("sub_wb_data", wb_data, 32'd2);
    check("sub_no_ovf", {31'b0, ovf_err}, 32'd0);

    // Burst: eight addi $6,$6,1 with in_valid held; queue fills once
    @(negedge clk);
    rdy_exp = 9'b1_0111_1111;  // bit c = expected in_ready in burst cycle c
    pushed  = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc <= 8) check($sformatf("burst_ready_c%0d", cyc), {31'b0, in_ready},
                          {31'b0, rdy_exp[cyc]});
      wb_exp = (cyc >= 3) && (cyc <= 17) && (cyc % 2 == 1);
      check($sformatf("burst_wb_c%0d", cyc), {31'b0, wb_valid}, {31'b0, wb_exp});
      if (wb_exp) begin
        check($sformatf("burst_data_c%0d", cyc), wb_data, 32'((cyc - 1) / 2));
        check($sformatf("burst_addr_c%0d", cyc), {27'b0, wb_addr}, 32'd6);
      end
      in_valid = (pushed < 8);
      in_instr = i_type(6'h08, 5'd6, 5'd6, 16'h0001);
      if (in_valid && in_ready) pushed++;
    end
    in_valid = 1'b0;
    check("burst_pushed", 32'(pushed), 32'd8);
    check_gpr("burst_gpr6", 5'd6, 32'd8);

    // Reset while addi $1,$0,7 sits in EXEC
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h2001_0007;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_alu_instr", alu_instr, 32'h2001_0007);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_alu_clr", alu_instr, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_mid_wb_%0d", k), {31'b0, wb_valid}, 32'd0);
      check($sformatf("rst_mid_pulses_%0d", k),
            {27'b0, branch_valid, mem_valid, ovf_err, ill_err, busy}, 32'd0);
      @(negedge clk);
    end
    check_gpr("rst_mid_gpr1", 5'd1, 32'd0);
    check_gpr("rst_mid_gpr6", 5'd6, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
